// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read single-port memory between the
// instruction-fetch port and the load/store data port of the rv32i core.
// Data normally wins a conflict so an in-flight load/store is never blocked
// by the next fetch; read data comes back one cycle after the grant to
// whichever requester owned the access.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to add a starvation
// counter that forces a fetch grant after STARVE_LIMIT consecutive data wins.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t owner;
    owner_t owner_nxt;
    logic   force_if;

    // Byte-offset bits are ignored; alignment is enforced upstream.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{if_addr[1:0], d_addr[1:0]};

    // The counter is only 4 bits wide, so the limit must fit in 1..15.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("mem_arbiter: STARVE_LIMIT must be in 1..15");
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    logic [3:0] starve_cnt;

    // Fetch is forced through once it has lost LIMIT conflicts in a row.
    assign force_if = if_req && (starve_cnt == LIMIT);

    // Count data grants that happen while fetch waits; saturate at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt || !if_req) begin
            starve_cnt <= 4'd0;
        end else if (d_gnt && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    // Without the guard, data strictly wins every conflict.
    assign force_if = 1'b0;
`endif

    // Pick a winner and steer the memory port to it; nothing is granted in reset.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        owner_nxt = OWN_NONE;
        if (rst_n) begin
            if (if_req && (force_if || !d_req)) begin
                if_gnt    = 1'b1;
                mem_en    = 1'b1;
                mem_be    = 4'hF;
                mem_addr  = if_addr[ADDR_W-1:2];
                owner_nxt = OWN_IF;
            end else if (d_req) begin
                d_gnt     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = d_we;
                // Loads always read the full word regardless of d_be.
                mem_be    = d_we ? d_be : 4'hF;
                mem_addr  = d_addr[ADDR_W-1:2];
                mem_wdata = d_wdata;
                owner_nxt = OWN_D;
            end
        end
    end

    // Remember who was granted so the next-cycle response is routed back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    // Route memory read data to the owner; rdata is held at zero otherwise.
    always_comb begin
        if_rvalid = (owner == OWN_IF);
        d_rvalid  = (owner == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        d_rdata   = d_rvalid  ? mem_rdata : 32'h0;
    end

endmodule
